// File: rtl/cordic_cos_iter_if.sv
// rtl/cordic_cos_iter_if.sv - enable/done handshake bundle for the CORDIC cos/sin engine
interface cordic_cos_iter_if #(
  parameter int WIDTH = 22
);
  logic                    enable;
  logic signed [WIDTH-1:0] angle;
  logic signed [WIDTH-1:0] cos_out;
  logic signed [WIDTH-1:0] sin_out;
  logic                    done;
  logic                    busy;
  logic                    range_err;

  modport master (
    output enable, angle,
    input  cos_out, sin_out, done, busy, range_err
  );

  modport slave (
    input  enable, angle,
    output cos_out, sin_out, done, busy, range_err
  );
endinterface

// File: rtl/cordic_cos_iter.sv
// rtl/cordic_cos_iter.sv - iterative CORDIC rotation, one micro-rotation per clock
// Computes cos/sin of a Q2.FRAC angle; gain K is preloaded so no output scaling is needed.
module cordic_cos_iter #(
  parameter int WIDTH      = 22,
  parameter int FRAC       = 20,
  parameter int ITERATIONS = 20
) (
  input  logic             clk,
  input  logic             reset,
  cordic_cos_iter_if.slave bus
);
  localparam int ZW = WIDTH + 2;
  localparam int IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [IW-1:0] LAST_ITER = IW'(ITERATIONS - 1);

  // atan(1/m) as an alternating series in Q.60, exact enough to round to FRAC bits
  function automatic longint atan_inv(input longint m);
    longint acc;
    longint pw;
    longint k;
    acc = 0;
    pw  = (64'sd1 <<< 60) / m;
    k   = 0;
    while (pw != 0) begin
      if (k[0]) acc = acc - pw / (2 * k + 1);
      else      acc = acc + pw / (2 * k + 1);
      pw = pw / (m * m);
      k  = k + 1;
    end
    return acc;
  endfunction

  function automatic longint atan_fix(input int i);
    longint v;
    if (i == 0)      v = atan_inv(64'sd2) + atan_inv(64'sd3);
    else if (i > 30) v = (64'sd1 <<< 60) >>> i;
    else             v = atan_inv(64'sd1 <<< i);
    return (v + (64'sd1 <<< (59 - FRAC))) >>> (60 - FRAC);
  endfunction

  localparam longint K_L = (64'sd6072529350 * (64'sd1 <<< FRAC) + 64'sd5000000000)
                           / 64'sd10000000000;
  localparam logic signed [ZW-1:0] K_FIX  = ZW'(K_L);
  localparam logic signed [ZW-1:0] ONE    = ZW'(64'sd1 <<< FRAC);
  localparam logic signed [ZW-1:0] SAT_HI = {{3{1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ZW-1:0] SAT_LO = {{3{1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [ZW-1:0] atan_tab [ITERATIONS];

  for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
    localparam longint ATAN_L = atan_fix(g);
    assign atan_tab[g] = ZW'(ATAN_L);
  end

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [ZW-1:0] v);
    if (v > SAT_HI)      return {1'b0, {(WIDTH-1){1'b1}}};
    else if (v < SAT_LO) return {1'b1, {(WIDTH-1){1'b0}}};
    else                 return v[WIDTH-1:0];
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FINISH} state_t;

  state_t               state, state_next;
  logic signed [ZW-1:0] x, y, z;
  logic        [IW-1:0] iter;
  logic                 range_pend;

  logic signed [ZW-1:0] angle_ext, angle_abs;
  logic signed [ZW-1:0] x_sh, y_sh, x_next, y_next, z_next;
  logic                 out_of_range;

  assign angle_ext    = {{2{bus.angle[WIDTH-1]}}, bus.angle};
  assign angle_abs    = angle_ext[ZW-1] ? -angle_ext : angle_ext;
  assign out_of_range = angle_abs > ONE;

  // z < 0 selects d = -1
  assign x_sh   = x >>> iter;
  assign y_sh   = y >>> iter;
  assign x_next = z[ZW-1] ? x + y_sh : x - y_sh;
  assign y_next = z[ZW-1] ? y - x_sh : y + x_sh;
  assign z_next = z[ZW-1] ? z + atan_tab[iter] : z - atan_tab[iter];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    case (state)
      S_IDLE:   if (bus.enable) state_next = S_ITER;
      S_ITER: begin
        bus.busy = 1'b1;
        if (iter == LAST_ITER) state_next = S_FINISH;
      end
      S_FINISH: begin
        bus.busy   = 1'b1;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x             <= '0;
      y             <= '0;
      z             <= '0;
      iter          <= '0;
      range_pend    <= 1'b0;
      bus.cos_out   <= '0;
      bus.sin_out   <= '0;
      bus.range_err <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.enable) begin
            x          <= K_FIX;
            y          <= '0;
            z          <= angle_ext;
            iter       <= '0;
            range_pend <= out_of_range;
          end
        end
        S_ITER: begin
          x    <= x_next;
          y    <= y_next;
          z    <= z_next;
          iter <= iter + 1'b1;
        end
        S_FINISH: begin
          bus.cos_out   <= sat(x);
          bus.sin_out   <= sat(y);
          bus.range_err <= range_pend;
          bus.done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_cos_iter.sv
// tb/tb_cordic_cos_iter.sv - scoreboard bench for cordic_cos_iter against real-valued cos/sin
module tb_cordic_cos_iter;
  localparam int  WIDTH = 22;
  localparam int  FRAC  = 20;
  localparam int  N     = 20;
  localparam int  ONE   = 1 << FRAC;
  localparam real SCALE = 1048576.0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cordic_cos_iter_if #(.WIDTH(WIDTH)) bus ();

  cordic_cos_iter #(.WIDTH(WIDTH), .FRAC(FRAC), .ITERATIONS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int angle;
    bit rerr;
    int tol;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int a, input int tol);
    exp_t e;
    e.angle = a;
    e.rerr  = (a > ONE) || (a < -ONE);
    e.tol   = tol;
    sb.push_back(e);
  endtask

  exp_t m_e;
  real  m_rc, m_rs, m_d;
  int   m_act;

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b0, 1, 0);
      end else begin
        m_e  = sb.pop_front();
        m_rc = $cos(real'(m_e.angle) / SCALE) * SCALE;
        m_rs = $sin(real'(m_e.angle) / SCALE) * SCALE;
        m_act = int'(bus.cos_out);
        m_d   = real'(m_act) - m_rc;
        check("cos_out", (m_d <= m_e.tol) && (m_d >= -m_e.tol), m_act, $rtoi(m_rc));
        m_act = int'(bus.sin_out);
        m_d   = real'(m_act) - m_rs;
        check("sin_out", (m_d <= m_e.tol) && (m_d >= -m_e.tol), m_act, $rtoi(m_rs));
        check("range_err", bus.range_err == m_e.rerr, bus.range_err, m_e.rerr);
        check("busy_with_done", bus.busy == 1'b0, bus.busy, 0);
      end
    end
  end

  task automatic do_op(input int a, input int tol, input bit intr, input int ia);
    int e;
    int nb;
    @(negedge clk);
    bus.enable = 1'b1;
    bus.angle  = WIDTH'(a);
    push_exp(a, tol);
    @(negedge clk);
    bus.enable = 1'b0;
    bus.angle  = WIDTH'($urandom);
    e  = 0;
    nb = 0;
    while (!bus.done && e < 100) begin
      if (bus.busy) nb++;
      bus.enable = intr && (e == 5);
      if (intr && e == 5) bus.angle = WIDTH'(ia);
      @(negedge clk);
      e++;
    end
    bus.enable = 1'b0;
    check("latency", e == N + 1, e, N + 1);
    check("busy_cycles", nb == N + 1, nb, N + 1);
  endtask

  initial begin
    int nd;
    int a;

    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.angle  = WIDTH'(ONE);
    repeat (2) @(negedge clk);
    check("rst_cos", bus.cos_out == 0, bus.cos_out, 0);
    check("rst_sin", bus.sin_out == 0, bus.sin_out, 0);
    check("rst_done", bus.done == 0, bus.done, 0);
    check("rst_busy", bus.busy == 0, bus.busy, 0);
    check("rst_rerr", bus.range_err == 0, bus.range_err, 0);
    reset      = 1'b0;
    bus.enable = 1'b0;
    @(negedge clk);
    check("idle_busy", bus.busy == 0, bus.busy, 0);
    check("idle_done", bus.done == 0, bus.done, 0);

    do_op(0, 8, 1'b0, 0);
    do_op(ONE, 8, 1'b0, 0);
    do_op(-ONE, 8, 1'b0, 0);
    do_op(1572864, 16, 1'b0, 0);

    do_op(300000, 8, 1'b1, -700000);
    repeat (30) @(negedge clk);
    check("ignored_enable_sb", sb.size() == 0, sb.size(), 0);

    nd = 0;
    for (int j = 0; j <= 4 * (N + 2); j++) begin
      @(negedge clk);
      if (j > 0 && bus.done) begin
        nd++;
        check("held_spacing", (j % (N + 2)) == 0, j, (j / (N + 2)) * (N + 2));
      end
      if (j < 4 * (N + 2)) begin
        bus.enable = 1'b1;
        a = int'($urandom_range(0, 2 * ONE)) - ONE;
        bus.angle = WIDTH'(a);
        if ((j % (N + 2)) == 0) push_exp(a, 16);
      end else begin
        bus.enable = 1'b0;
      end
    end
    check("held_done_count", nd == 4, nd, 4);

    @(negedge clk);
    bus.enable = 1'b1;
    bus.angle  = WIDTH'(500000);
    @(negedge clk);
    bus.enable = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cos", bus.cos_out == 0, bus.cos_out, 0);
    check("midrst_sin", bus.sin_out == 0, bus.sin_out, 0);
    check("midrst_busy", bus.busy == 0, bus.busy, 0);
    check("midrst_done", bus.done == 0, bus.done, 0);
    reset = 1'b0;
    nd = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("midrst_no_done", nd == 0, nd, 0);
    do_op(0, 8, 1'b0, 0);

    repeat (16) begin
      a = int'($urandom_range(0, 2 * 1730150)) - 1730150;
      do_op(a, 16, 1'b0, 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size() == 0, sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
